pwm_decoder: RTL



---
 rtl/pwm_decoder_if.sv | 31 +++
 rtl/pwm_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if -- measurement bus between a PWM source and pwm_decoder.
//
//   i_pwm      raw PWM waveform into the decoder (asynchronous to clk)
//   o_duty     high time of the last complete period, clk cycles
//   o_period   rise-to-rise length of the last complete period, clk cycles
//   o_valid    one-cycle strobe: o_duty/o_period updated this cycle
//   o_timeout  level: no expected edge within the timeout window
//   o_level    input level captured when the timeout fired
//
// master: the side that drives i_pwm and consumes the measurements.
// slave : the decoder itself.
interface pwm_decoder_if #(
  parameter int CW = 14
);
  logic          i_pwm;
  logic [CW-1:0] o_duty;
  logic [CW-1:0] o_period;
  logic          o_valid;
  logic          o_timeout;
  logic          o_level;

  modport master (
    output i_pwm,
    input  o_duty, o_period, o_valid, o_timeout, o_level
  );

  modport slave (
    input  i_pwm,
    output o_duty, o_period, o_valid, o_timeout, o_level
  );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder -- measures an incoming PWM waveform and reports its high time
// and period in clk cycles, in the same units as the generator's duty input.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset; clears every flop
//   bus    pwm_decoder_if.slave (i_pwm in; o_duty, o_period, o_valid,
//          o_timeout, o_level out)
//
// Optional build macro:
//   PWM_DECODER_GLITCH_FILTER_EN -- inserts a FILT_LEN-cycle persistence
//   filter between the synchronizer and the edge detector. Pulses or gaps
//   shorter than FILT_LEN cycles are dropped. Both edges are delayed equally,
//   so measurements are unchanged; only edge-to-o_valid latency grows.
//
// Timing: with rise at cycle r, fall at f and the next rise at r2, the report
// is duty = f-r, period = r2-r. A period longer than TIMEOUT_CNT (or a stuck
// input) is reported as a timeout, never as a wrapped count.
module pwm_decoder #(
  parameter int CLK_FREQ    = 100000000,
  parameter int PWM_FREQ    = 20000,
  parameter int TIMEOUT_CNT = 2*(CLK_FREQ/PWM_FREQ+1),
  parameter int CW          = $clog2(TIMEOUT_CNT+1)
)(
  input  logic          clk,
  input  logic          reset,
  pwm_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  typedef struct packed {
    logic [CW-1:0] duty;
    logic [CW-1:0] period;
  } meas_t;

  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CNT);

  // ---------------------------------------------------------------------------
  // Input synchronizer; r_sync2 is the clean pwm_s
  // ---------------------------------------------------------------------------
  logic r_sync1, r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.i_pwm;
      r_sync2 <= r_sync1;
    end
  end

  // Level seen by the edge detector (filtered or straight from the sync)
  logic w_pwm_f;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int FILT_LEN = 4;
  localparam int FW       = $clog2(FILT_LEN);

  logic          r_filt;
  logic [FW-1:0] r_fcnt;

  // r_fcnt counts consecutive cycles where pwm_s disagrees with the filter
  // output; the output flips on the FILT_LEN-th such cycle. Any agreement
  // restarts the count, so short pulses and gaps never get through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILT_LEN-1)) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end

  assign w_pwm_f = r_filt;
`else
  assign w_pwm_f = r_sync2;
`endif

  // ---------------------------------------------------------------------------
  // Edge detector
  // ---------------------------------------------------------------------------
  logic r_pwm_d;
  logic w_rise, w_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pwm_d <= 1'b0;
    else       r_pwm_d <= w_pwm_f;
  end

  assign w_rise =  w_pwm_f & ~r_pwm_d;
  assign w_fall = ~w_pwm_f &  r_pwm_d;

  // ---------------------------------------------------------------------------
  // Cycle counter: restarts at 1 after each rise, saturates at TIMEOUT_CNT so
  // an overlong period can never wrap into a plausible-looking value.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic          w_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_cnt <= '0;
    else if (w_rise)          r_cnt <= CW'(1);
    else if (r_cnt != TO_MAX) r_cnt <= r_cnt + CW'(1);
  end

  assign w_sat = (r_cnt == TO_MAX);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t r_state, w_state_nxt;
  logic   w_cap_high;   // latch high time at the fall
  logic   w_report;     // publish a full rise-fall-rise measurement
  logic   w_to_evt;     // expected edge missed within the window

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // In HIGH only a fall can occur and in LOW only a rise, so checking the
  // edge first is enough to honour "timeout only with no edge this cycle".
  // A rise landing exactly on cnt==TIMEOUT_CNT is still a valid period.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_high  = 1'b0;
    w_report    = 1'b0;
    w_to_evt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = HIGH;
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nxt = LOW;
          w_cap_high  = 1'b1;
        end else if (w_sat) begin
          w_state_nxt = IDLE;
          w_to_evt    = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_report    = 1'b1;
        end else if (w_sat) begin
          w_state_nxt = IDLE;
          w_to_evt    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Measurement / status registers
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_high;
  meas_t         r_meas;
  logic          r_valid;
  logic          r_timeout;
  logic          r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_high    <= '0;
      r_meas    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_valid <= w_report;
      if (w_cap_high) r_high <= r_cnt;
      if (w_report) begin
        r_meas.duty   <= r_high;
        r_meas.period <= r_cnt;
        r_timeout     <= 1'b0;
      end
      // Last good measurement is kept across a timeout.
      if (w_to_evt) begin
        r_timeout <= 1'b1;
        r_level   <= w_pwm_f;
      end
    end
  end

  assign bus.o_duty    = r_meas.duty;
  assign bus.o_period  = r_meas.period;
  assign bus.o_valid   = r_valid;
  assign bus.o_timeout = r_timeout;
  assign bus.o_level   = r_level;

endmodule
